cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate L1 controller; sits directly upstream of Data_Memory.
- Serves single-word CPU reads and writes from a 32-line × 4-word store.
- Read misses issue a line fill to Data_Memory (128-bit line); every write goes through to Data_Memory.
- CPU is held with stall while a memory transaction is outstanding.

Parameters:
- LINES, 32, number of cache lines (power of 2); index width = log2(LINES)
- WORDS_PER_LINE, 4, fixed at 4 to match the 128-bit mem_data_out; offset width 2
- ADDR_W, 10, word-address width shared with Data_Memory

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_read  in  1  read request, held until stall=0
- cpu_write  in  1  write request, held until stall=0; mutually exclusive with cpu_read
- cpu_addr  in  10  word address: tag[9:7], index[6:2], offset[1:0]
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid in the cycle stall=0 with cpu_read=1
- stall  out  1  CPU must hold its request while stall=1
- mem_read_access  out  1  line-fill request to Data_Memory
- mem_write_access  out  1  word write-through request
- mem_address  out  10  read: {tag,index,2'b00}; write: cpu_addr
- mem_control_data  out  32  write-through data
- mem_ready  in  1  completion from Data_Memory
- mem_data_out  in  128  fill line; word n at bits [32n+31:32n]

Behaviour:
Reset values:
- All valid bits 0; state IDLE.
- stall, mem_read_access, mem_write_access, cpu_rdata, mem_address, mem_control_data all 0.
- Line data and tags are not reset.

States: IDLE, RD_REQ, RD_WAIT, FILL, WR_REQ, WR_WAIT.

IDLE, read hit (valid and tag match):
- stall=0; cpu_rdata = addressed word combinationally, same cycle. Latency 0.

IDLE, read miss:
- stall=1 combinationally.
- Next state RD_REQ; latch tag, index and offset.

RD_REQ:
- Drive mem_read_access=1 and mem_address={tag,index,2'b00}.
- Next state RD_WAIT.
- mem_ready is not sampled here; a stale high ready left from an earlier transaction is ignored.

RD_WAIT:
- Hold the request until mem_ready=1.
- On that edge: capture mem_data_out into the line, write the tag, set valid, drop mem_read_access, go to FILL.

FILL:
- stall=0; cpu_rdata = latched-offset word from the new line.
- Return to IDLE.
- Read-miss latency = memory latency + 2 cycles.

Write, any hit or miss:
- IDLE → WR_REQ (stall=1); latch address and data.
- On a hit, the cached word is updated at that same edge. On a miss, line state is unchanged.

WR_REQ:
- Drive mem_write_access=1, mem_address, mem_control_data.
- Next state WR_WAIT.

WR_WAIT:
- On mem_ready=1: drop the request, stall=0 for one cycle, return to IDLE.

Access rules:
- mem_read_access and mem_write_access are never both 1.
- Requests are held stable until mem_ready is seen.
- cpu_read and cpu_write both 1 is illegal; write takes priority.
- A CPU request that changes while stall=1 is ignored; the latched values are used.
- Index wrap-around is not applicable: indexing is a pure bit slice.

Reset mid-transaction:
- Returns to IDLE immediately and clears all valid bits.
- Memory-side requests drop asynchronously.
- No partial fill is committed.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined: adds outputs hit_count[15:0] and miss_count[15:0]. They count CPU reads at acceptance (hit in IDLE, miss on IDLE→RD_REQ), saturate at 16'hFFFF, and reset to 0.
- Writes are not counted.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - constants LINES, INDEX_W=5, TAG_W=3, OFFSET_W=2, LINE_W=128
  - the state enum typedef
  - tag/index/offset field-extraction functions
- One sub-module, cache_line_store: the valid/tag/data arrays.
  - Combinational read port.
  - One synchronous port for a full-line fill.
  - One synchronous port for a single-word update.
  - Async valid clear on reset.

Test Plan:
1. Cold read of addr 10'h024: memory returns line with word0 = 32'hAAAA_0000 after 4 cycles. Required: mem_address=10'h024, stall high for 6 cycles, then cpu_rdata=32'hAAAA_0000.
2. Read 10'h025 immediately after scenario 1: hit, stall=0 in the same cycle, no mem request, data = word1 of the filled line.
3. Write 32'hDEAD_BEEF to 10'h026 (hit): mem_write_access with mem_address=10'h026. A later read of 10'h026 hits and returns 32'hDEAD_BEEF with no fill.
4. Write 32'h1234_5678 to 10'h3F0 (miss): write-through only. A later read of 10'h3F0 misses and issues a fill at 10'h3F0.
5. Conflict: read 10'h004, then read 10'h084 (same index, different tag), then read 10'h004. Required: three fills.
6. Assert reset while in RD_WAIT: stall=0 and mem_read_access=0 asynchronously. A following read of the same address misses (valid cleared).

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address field helpers for the L1 cache controller.
package cache_pkg;
    localparam int LINES          = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int ADDR_W         = 10;
    localparam int INDEX_W        = 5;
    localparam int TAG_W          = 3;
    localparam int OFFSET_W       = 2;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 128;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        FILL,
        WR_REQ,
        WR_WAIT
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction
endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays: combinational word read, full-line fill port, single-word update port.
module cache_line_store
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [WORD_W-1:0]   rd_word,
    input  logic                fill_en,
    input  logic [INDEX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [LINE_W-1:0]   fill_line,
    input  logic                word_en,
    input  logic [INDEX_W-1:0]  word_index,
    input  logic [OFFSET_W-1:0] word_offset,
    input  logic [WORD_W-1:0]   word_data
);
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [WORD_W-1:0] data [LINES][WORDS_PER_LINE];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_word  = data[rd_index][rd_offset];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            valid <= '0;
        else if (fill_en)
            valid[fill_index] <= 1'b1;
    end

    // Tags and data are deliberately not reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[fill_index] <= fill_tag;
            for (int w = 0; w < WORDS_PER_LINE; w++)
                data[fill_index][w] <= fill_line[w*WORD_W +: WORD_W];
        end else if (word_en) begin
            data[word_index][word_offset] <= word_data;
        end
    end
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-through, no-write-allocate L1 controller in front of Data_Memory.
// Optional macro CACHE_STATS_EN adds saturating read hit/miss counters.
module cache_controller
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [WORD_W-1:0]   cpu_wdata,
    output logic [WORD_W-1:0]   cpu_rdata,
    output logic                stall,
    output logic                mem_read_access,
    output logic                mem_write_access,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [WORD_W-1:0]   mem_control_data,
    input  logic                mem_ready,
    input  logic [LINE_W-1:0]   mem_data_out
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
`endif
);
    state_t              state;
    logic [OFFSET_W-1:0] lat_offset;
    logic [INDEX_W-1:0]  rd_index;
    logic [OFFSET_W-1:0] rd_offset;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [WORD_W-1:0]   rd_word;
    logic                hit;
    logic                fill_en;
    logic                word_en;

    // During FILL the read port looks at the latched line, otherwise at the live CPU address.
    assign rd_index  = (state == FILL) ? addr_index(mem_address) : addr_index(cpu_addr);
    assign rd_offset = (state == FILL) ? lat_offset : addr_offset(cpu_addr);
    assign hit       = rd_valid && (rd_tag == addr_tag(cpu_addr));
    assign fill_en   = (state == RD_WAIT) && mem_ready;
    assign word_en   = !reset && (state == IDLE) && cpu_write && hit;

    cache_line_store u_store (
        .clk         (clk),
        .reset       (reset),
        .rd_index    (rd_index),
        .rd_offset   (rd_offset),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_word     (rd_word),
        .fill_en     (fill_en),
        .fill_index  (addr_index(mem_address)),
        .fill_tag    (addr_tag(mem_address)),
        .fill_line   (mem_data_out),
        .word_en     (word_en),
        .word_index  (addr_index(cpu_addr)),
        .word_offset (addr_offset(cpu_addr)),
        .word_data   (cpu_wdata)
    );

    always_comb begin
        stall     = 1'b0;
        cpu_rdata = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (cpu_write)
                        stall = 1'b1;
                    else if (cpu_read) begin
                        if (hit)
                            cpu_rdata = rd_word;
                        else
                            stall = 1'b1;
                    end
                end
                RD_REQ, RD_WAIT, WR_REQ: stall = 1'b1;
                FILL:    cpu_rdata = rd_word;
                WR_WAIT: stall = !mem_ready;
                default: stall = 1'b0;
            endcase
        end
    end

    // mem_address doubles as the latched tag/index for the outstanding line fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            mem_read_access  <= 1'b0;
            mem_write_access <= 1'b0;
            mem_address      <= '0;
            mem_control_data <= '0;
            lat_offset       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_write) begin
                        state            <= WR_REQ;
                        mem_write_access <= 1'b1;
                        mem_address      <= cpu_addr;
                        mem_control_data <= cpu_wdata;
                    end else if (cpu_read && !hit) begin
                        state           <= RD_REQ;
                        mem_read_access <= 1'b1;
                        mem_address     <= {addr_tag(cpu_addr), addr_index(cpu_addr), {OFFSET_W{1'b0}}};
                        lat_offset      <= addr_offset(cpu_addr);
                    end
                end
                RD_REQ:  state <= RD_WAIT;
                RD_WAIT: begin
                    if (mem_ready) begin
                        mem_read_access <= 1'b0;
                        state           <= FILL;
                    end
                end
                FILL:    state <= IDLE;
                WR_REQ:  state <= WR_WAIT;
                WR_WAIT: begin
                    if (mem_ready) begin
                        mem_write_access <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && cpu_read && !cpu_write) begin
            if (hit) begin
                if (hit_count != 16'hFFFF)
                    hit_count <= hit_count + 16'd1;
            end else if (miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: vector table of CPU accesses plus reset corner sequences.
module tb_cache_controller;
    localparam int MEM_LAT   = 4;
    localparam int MAX_STALL = 40;

    logic         clk;
    logic         reset;
    logic         cpu_read;
    logic         cpu_write;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         stall;
    logic         mem_read_access;
    logic         mem_write_access;
    logic [9:0]   mem_address;
    logic [31:0]  mem_control_data;
    logic         mem_ready;
    logic [127:0] mem_data_out;
`ifdef CACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    cache_controller dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_read         (cpu_read),
        .cpu_write        (cpu_write),
        .cpu_addr         (cpu_addr),
        .cpu_wdata        (cpu_wdata),
        .cpu_rdata        (cpu_rdata),
        .stall            (stall),
        .mem_read_access  (mem_read_access),
        .mem_write_access (mem_write_access),
        .mem_address      (mem_address),
        .mem_control_data (mem_control_data),
        .mem_ready        (mem_ready),
        .mem_data_out     (mem_data_out)
`ifdef CACHE_STATS_EN
        ,
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int both_seen = 0;
    logic [31:0] mem_words [1024];

    // Memory model: ready pulses MEM_LAT cycles after a request first appears.
    initial begin
        int cnt;
        int base;
        cnt = 0;
        mem_ready = 1'b0;
        mem_data_out = '0;
        for (int a = 0; a < 1024; a++)
            mem_words[a] = 32'hAAAA_0000 + a - 32'h24;
        forever begin
            @(negedge clk);
            if (mem_read_access || mem_write_access) begin
                cnt++;
                base = {22'd0, mem_address[9:2], 2'b00};
                mem_data_out = {mem_words[base+3], mem_words[base+2], mem_words[base+1], mem_words[base]};
                if (cnt == MEM_LAT + 1) begin
                    mem_ready = 1'b1;
                    if (mem_write_access)
                        mem_words[mem_address] = mem_control_data;
                end else begin
                    mem_ready = 1'b0;
                end
            end else begin
                cnt = 0;
                mem_ready = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One CPU access: returns stalled cycles, read data and the memory request observed.
    task automatic do_access(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                             input logic perturb, output int stalls, output logic [31:0] rdata,
                             output int kind, output logic [9:0] maddr);
        stalls = 0;
        kind = 0;
        maddr = '0;
        @(negedge clk);
        cpu_read  = !wr;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        #1;
        forever begin
            if (mem_read_access && mem_write_access) both_seen++;
            if (mem_read_access) begin kind = kind | 1; maddr = mem_address; end
            if (mem_write_access) begin kind = kind | 2; maddr = mem_address; end
            if (!stall || stalls >= MAX_STALL) break;
            stalls++;
            if (perturb && stalls == 2) begin
                cpu_addr  = addr ^ 10'h3FF;
                cpu_wdata = ~wdata;
            end
            @(negedge clk);
            #1;
        end
        rdata = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        perturb;
        int          exp_stalls;
        int          exp_kind;
        logic [9:0]  exp_maddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int stalls;
        int kind;
        logic [31:0] rdata;
        logic [9:0] maddr;

        // kind: 0 none, 1 line fill, 2 write-through
        vecs[0]  = '{1'b0, 10'h024, 32'h0,         1'b0, 6, 1, 10'h024, 32'hAAAA_0000};
        vecs[1]  = '{1'b0, 10'h025, 32'h0,         1'b0, 0, 0, 10'h000, 32'hAAAA_0001};
        vecs[2]  = '{1'b1, 10'h026, 32'hDEAD_BEEF, 1'b0, 5, 2, 10'h026, 32'h0};
        vecs[3]  = '{1'b0, 10'h026, 32'h0,         1'b0, 0, 0, 10'h000, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 10'h3F0, 32'h1234_5678, 1'b0, 5, 2, 10'h3F0, 32'h0};
        vecs[5]  = '{1'b0, 10'h3F0, 32'h0,         1'b0, 6, 1, 10'h3F0, 32'h1234_5678};
        vecs[6]  = '{1'b0, 10'h004, 32'h0,         1'b0, 6, 1, 10'h004, 32'hAAA9_FFE0};
        vecs[7]  = '{1'b0, 10'h084, 32'h0,         1'b0, 6, 1, 10'h084, 32'hAAAA_0060};
        vecs[8]  = '{1'b0, 10'h004, 32'h0,         1'b0, 6, 1, 10'h004, 32'hAAA9_FFE0};
        vecs[9]  = '{1'b0, 10'h027, 32'h0,         1'b0, 0, 0, 10'h000, 32'hAAAA_0003};
        vecs[10] = '{1'b0, 10'h046, 32'h0,         1'b1, 6, 1, 10'h044, 32'hAAAA_0022};
        vecs[11] = '{1'b1, 10'h047, 32'h0000_5555, 1'b1, 5, 2, 10'h047, 32'h0};
        vecs[12] = '{1'b0, 10'h047, 32'h0,         1'b0, 0, 0, 10'h000, 32'h0000_5555};
        vecs[13] = '{1'b0, 10'h044, 32'h0,         1'b0, 0, 0, 10'h000, 32'hAAAA_0020};

        reset = 1'b1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_mem_rd", {31'd0, mem_read_access}, 32'd0);
        check("reset_mem_wr", {31'd0, mem_write_access}, 32'd0);
        check("reset_mem_addr", {22'd0, mem_address}, 32'd0);
        check("reset_mem_wdata", mem_control_data, 32'd0);
        check("reset_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].perturb, stalls, rdata, kind, maddr);
            check($sformatf("v%0d_stall_cycles", i), 32'(stalls), 32'(vecs[i].exp_stalls));
            check($sformatf("v%0d_mem_req", i), 32'(kind), 32'(vecs[i].exp_kind));
            if (vecs[i].exp_kind != 0)
                check($sformatf("v%0d_mem_addr", i), {22'd0, maddr}, {22'd0, vecs[i].exp_maddr});
            if (!vecs[i].wr)
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end

        check("wt_mem_026", mem_words[10'h026], 32'hDEAD_BEEF);
        check("wt_mem_047_latched", mem_words[10'h047], 32'h0000_5555);

        // Reset while the line fill for 0x050 is waiting on memory.
        @(negedge clk);
        cpu_read = 1'b1;
        cpu_addr = 10'h050;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rdwait_stall", {31'd0, stall}, 32'd1);
        check("rdwait_mem_rd", {31'd0, mem_read_access}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_stall", {31'd0, stall}, 32'd0);
        check("async_rst_mem_rd", {31'd0, mem_read_access}, 32'd0);
        cpu_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        do_access(1'b0, 10'h050, 32'h0, 1'b0, stalls, rdata, kind, maddr);
        check("post_rst_050_stall", 32'(stalls), 32'd6);
        check("post_rst_050_req", 32'(kind), 32'd1);
        check("post_rst_050_rdata", rdata, 32'hAAAA_002C);
        do_access(1'b0, 10'h024, 32'h0, 1'b0, stalls, rdata, kind, maddr);
        check("post_rst_024_stall", 32'(stalls), 32'd6);
        check("post_rst_024_addr", {22'd0, maddr}, 32'h024);
        check("post_rst_024_rdata", rdata, 32'hAAAA_0000);

        check("no_dual_request", 32'(both_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
